ps2_key_decoder: RTL

//  Converts the PS/2 scan-code byte stream (set 2) from the PS/2 receiver into held key levels
//  key_space / key_right / key_left, the movement inputs of draw_rect_ctl.

---
 rtl/ps2_key_decoder.sv | 106 ++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 scan-code stream to held space/right/left key levels
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter logic [7:0]  CODE_SPACE     = 8'h29,
  parameter logic [7:0]  CODE_D         = 8'h23,
  parameter logic [7:0]  CODE_A         = 8'h1C,
  parameter logic [7:0]  CODE_ARR_R     = 8'h74,
  parameter logic [7:0]  CODE_ARR_L     = 8'h6B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       key_space_o,
  output logic       key_right_o,
  output logic       key_left_o,
  output logic       key_event_o
);
  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_e;
  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [2:0]    skip_q, skip_d;
  logic [4:0]    flg_q, flg_d;
  logic [2:0]    out_q, out_d;
  logic          evt_q, evt_d;
  logic          pre, mk, bk, ext;
  logic [4:0]    sel;
  assign pre = rx_data_i == 8'hE0 || rx_data_i == 8'hF0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    mk      = 1'b0;
    bk      = 1'b0;
    ext     = 1'b0;
    if (rx_valid_i) begin
      cnt_d = '0;
      if (rx_data_i == 8'hAA) begin
        state_d = IDLE;
        skip_d  = '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = rx_data_i == 8'hE0 ? EXT : rx_data_i == 8'hF0 ? BRK : rx_data_i == 8'hE1 ? SKIP : IDLE;
            skip_d  = rx_data_i == 8'hE1 ? 3'd7 : 3'd0;
            mk      = state_d == IDLE && !(rx_data_i inside {8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF});
          end
          EXT: begin
            state_d = rx_data_i == 8'hF0 ? EXT_BRK : rx_data_i == 8'hE0 ? EXT : IDLE;
            mk      = !pre;
            ext     = 1'b1;
          end
          BRK: begin
            state_d = IDLE;
            bk      = !pre;
          end
          EXT_BRK: begin
            state_d = IDLE;
            bk      = !pre;
            ext     = 1'b1;
          end
          SKIP: begin
            state_d = skip_q <= 3'd1 ? IDLE : SKIP;
            skip_d  = skip_q <= 3'd1 ? 3'd0 : skip_q - 3'd1;
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q != IDLE) begin
      // an abandoned prefix is dropped, but keys already held stay held
      cnt_d = cnt_q == TMO_LAST ? '0 : cnt_q + 1'b1;
      if (cnt_q == TMO_LAST) begin
        state_d = IDLE;
        skip_d  = '0;
      end
    end else begin
      cnt_d = '0;
    end
    sel   = {ext && rx_data_i == CODE_ARR_L, ext && rx_data_i == CODE_ARR_R,
             !ext && rx_data_i == CODE_A, !ext && rx_data_i == CODE_D, !ext && rx_data_i == CODE_SPACE};
    flg_d = rx_valid_i && rx_data_i == 8'hAA ? 5'd0 : mk ? flg_q | sel : bk ? flg_q & ~sel : flg_q;
    out_d = {flg_d[0], flg_d[1] | flg_d[3], flg_d[2] | flg_d[4]};
    evt_d = out_d != out_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      skip_q  <= '0;
      flg_q   <= '0;
      out_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      flg_q   <= flg_d;
      out_q   <= out_d;
      evt_q   <= evt_d;
    end
  end
  assign {key_space_o, key_right_o, key_left_o} = out_q;
  assign key_event_o = evt_q;
endmodule
